// File: rtl/mips_mem_region_router.sv
// mips_mem_region_router
// Runtime-programmable N-region address decoder between the CPU load/store
// port and memory/MMIO slaves. Each accepted request is registered for one
// cycle and either forwarded with a one-hot region select and region-relative
// offset, or consumed and recorded as a fault (miss or store to read-only).
module mips_mem_region_router #(
  parameter int ADDR_W     = 32,
  parameter int N_REGIONS  = 4,
  parameter int TEXT_BYTES = 1024,
  parameter int DATA_BYTES = 1024,
  parameter int MMIO_BYTES = 256,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(N_REGIONS)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]            cfg_base,
  input  logic [ADDR_W-1:0]            cfg_limit,
  input  logic                         cfg_ro,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic                         in_we,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_REGIONS-1:0]         out_sel,
  output logic [ADDR_W-1:0]            out_offset,
  output logic                         out_we,
  output logic                         fault,
  output logic [ADDR_W-1:0]            fault_addr,
  output logic [CNT_W-1:0]             fault_cnt,
  input  logic                         fault_clr
);

  // Default MIPS memory map
  localparam logic [ADDR_W-1:0] TEXT_BASE   = ADDR_W'(32'h0040_0000);
  localparam logic [ADDR_W-1:0] TEXT_LIMIT  = TEXT_BASE + ADDR_W'(TEXT_BYTES - 1);
  localparam logic [ADDR_W-1:0] DATA_BASE   = ADDR_W'(32'h1001_0000);
  localparam logic [ADDR_W-1:0] DATA_LIMIT  = DATA_BASE + ADDR_W'(DATA_BYTES / 2 - 1);
  localparam logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(32'h7fff_effc);
  localparam logic [ADDR_W-1:0] STACK_BASE  = STACK_LIMIT - ADDR_W'(DATA_BYTES / 2);
  localparam logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(32'hffff_0000);
  localparam logic [ADDR_W-1:0] MMIO_LIMIT  = MMIO_BASE + ADDR_W'(MMIO_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  logic [ADDR_W-1:0]    reg_base  [N_REGIONS];
  logic [ADDR_W-1:0]    reg_limit [N_REGIONS];
  logic                 reg_ro    [N_REGIONS];

  logic                 hit;
  logic                 hit_ro;
  logic [N_REGIONS-1:0] hit_sel;
  logic [ADDR_W-1:0]    hit_base;
  logic                 accept;
  logic                 blocked;
  logic                 fwd;
  logic                 flt;

  // Region table: defaults on reset, single-entry runtime writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REGIONS; i++) begin
        reg_base[i]  <= '1;
        reg_limit[i] <= '0;
        reg_ro[i]    <= 1'b0;
      end
      reg_base[0]  <= TEXT_BASE;
      reg_limit[0] <= TEXT_LIMIT;
      reg_ro[0]    <= 1'b1;
      reg_base[1]  <= DATA_BASE;
      reg_limit[1] <= DATA_LIMIT;
      reg_base[2]  <= STACK_BASE;
      reg_limit[2] <= STACK_LIMIT;
      reg_base[3]  <= MMIO_BASE;
      reg_limit[3] <= MMIO_LIMIT;
    end else if (cfg_we && (int'(cfg_idx) < N_REGIONS)) begin
      reg_base[cfg_idx]  <= cfg_base;
      reg_limit[cfg_idx] <= cfg_limit;
      reg_ro[cfg_idx]    <= cfg_ro;
    end
  end

  // Priority decode of in_addr against the current (pre-write) table; lowest index wins
  always_comb begin
    hit      = 1'b0;
    hit_ro   = 1'b0;
    hit_sel  = '0;
    hit_base = '0;
    for (int unsigned i = 0; i < N_REGIONS; i++) begin
      if (!hit && (reg_base[i] <= in_addr) && (in_addr <= reg_limit[i])) begin
        hit        = 1'b1;
        hit_ro     = reg_ro[i];
        hit_sel[i] = 1'b1;
        hit_base   = reg_base[i];
      end
    end
  end

  // Handshake and request classification
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    blocked  = !hit || (in_we && hit_ro);
    fwd      = accept && !blocked;
    flt      = accept && blocked;
  end

  // Output register stage; fields only change when a new request is forwarded
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sel    <= '0;
      out_offset <= '0;
      out_we     <= 1'b0;
    end else if (fwd) begin
      out_valid  <= 1'b1;
      out_sel    <= hit_sel;
      out_offset <= in_addr - hit_base;
      out_we     <= in_we;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky fault state; a fault accepted together with fault_clr restarts the count at 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= '0;
      fault_cnt  <= '0;
    end else if (flt) begin
      fault      <= 1'b1;
      fault_addr <= in_addr;
      if (fault_clr)
        fault_cnt <= CNT_W'(1);
      else if (fault_cnt != CNT_MAX)
        fault_cnt <= fault_cnt + CNT_W'(1);
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_addr <= '0;
      fault_cnt  <= '0;
    end
  end

endmodule
